// File: rtl/week6_ex1_lut3_pipeline.sv
// Bitwise 3-input LUT behind an elastic valid/ready pipeline, with a built-in
// self-test that sweeps all eight input combinations through the datapath.
module week6_ex1_lut3_pipeline #(
   parameter int unsigned WIDTH  = 8,
   parameter logic [7:0]  TT     = 8'h8B,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   input  logic             fault_inject,
   input  logic             selftest_start,
   output logic             selftest_busy,
   output logic             selftest_done,
   output logic             selftest_pass,
   output logic [3:0]       err_count
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   ret_q, ret_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               pass_q, pass_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               live_q;

   logic [STAGES-1:0]  valid_q, valid_d;
   logic [WIDTH-1:0]   data_q [STAGES];
   logic [WIDTH-1:0]   data_d [STAGES];

   logic [STAGES-1:0]  load_c;
   logic               bist_own_c;
   logic               drain_last_c;
   logic               src_valid_c;
   logic [WIDTH-1:0]   src_data_c;
   logic [WIDTH-1:0]   check_exp_c;

   function automatic logic [WIDTH-1:0] lut3(input logic [WIDTH-1:0] fa,
                                             input logic [WIDTH-1:0] fb,
                                             input logic [WIDTH-1:0] fc);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = TT[{fa[i], fb[i], fc[i]}];
      end
      return r;
   endfunction

   // Load/drain chain: a stage loads when empty or when it moves on this cycle.
   always_comb begin
      bist_own_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      drain_last_c = valid_q[STAGES-1] & (bist_own_c | out_ready);
      load_c       = '0;
      load_c[STAGES-1] = ~valid_q[STAGES-1] | drain_last_c;
      for (int k = STAGES - 2; k >= 0; k--) begin
         load_c[k] = ~valid_q[k] | load_c[k+1];
      end
      in_ready = live_q & (state_q == ST_IDLE) & load_c[0];
   end

   // Stage-0 source: BIST pattern while running, otherwise the external operands.
   always_comb begin
      src_valid_c = 1'b0;
      src_data_c  = '0;
      if (state_q == ST_RUN) begin
         src_valid_c = 1'b1;
         src_data_c  = lut3({WIDTH{idx_q[2]}}, {WIDTH{idx_q[1]}}, {WIDTH{idx_q[0]}});
      end else begin
         src_valid_c = in_valid & in_ready;
         src_data_c  = lut3(a, b, c);
      end
      src_data_c = src_data_c ^ WIDTH'(fault_inject);
   end

   always_comb begin
      valid_d = valid_q;
      for (int k = 0; k < STAGES; k++) begin
         data_d[k] = data_q[k];
      end
      if (load_c[0]) begin
         valid_d[0] = src_valid_c;
         if (src_valid_c) data_d[0] = src_data_c;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (load_c[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) data_d[k] = data_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   // BIST sequencing and result checking; a returned beat fails when any bit
   // the truth table says must be set has come back cleared.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ret_d       = ret_q;
      err_d       = err_q;
      pass_d      = pass_q;
      check_exp_c = {WIDTH{TT[ret_q[2:0]]}};
      unique case (state_q)
         ST_IDLE: begin
            if (selftest_start && (valid_q == '0)) begin
               err_d   = '0;
               ret_d   = '0;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            idx_d = 3'(idx_q + 3'd1);
            if (idx_q == 3'd7) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = ST_DRAIN;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (bist_own_c && valid_q[STAGES-1]) begin
         ret_d = CNT_W'(ret_q + 1'b1);
         if ((data_q[STAGES-1] & check_exp_c) != check_exp_c) begin
            err_d = CNT_W'(err_q + 1'b1);
         end
         if (ret_q == CNT_W'(7)) state_d = ST_DONE;
      end
      if (state_d == ST_DONE) pass_d = (err_d == '0);
      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ret_q   <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         live_q  <= 1'b1;
      end
   end

   // BIST results never reach the external consumer.
   assign out_valid     = valid_q[STAGES-1] & ~busy_q;
   assign y             = data_q[STAGES-1];
   assign selftest_busy = busy_q;
   assign selftest_done = done_q;
   assign selftest_pass = pass_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_week6_ex1_lut3_pipeline.sv
// Directed self-checking bench for week6_ex1_lut3_pipeline (WIDTH=8, TT=8'h8B, STAGES=2).
module tb_week6_ex1_lut3_pipeline;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned STAGES = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [WIDTH-1:0] c = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] y;
   logic             fault_inject = 1'b0;
   logic             selftest_start = 1'b0;
   logic             selftest_busy;
   logic             selftest_done;
   logic             selftest_pass;
   logic [3:0]       err_count;

   int n_tests = 0;
   int n_fail  = 0;

   week6_ex1_lut3_pipeline #(.WIDTH(WIDTH), .TT(8'h8B), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c),
      .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .fault_inject(fault_inject),
      .selftest_start(selftest_start), .selftest_busy(selftest_busy),
      .selftest_done(selftest_done), .selftest_pass(selftest_pass),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_y(input logic [7:0] fa, input logic [7:0] fb,
                                        input logic [7:0] fc);
      return (~fa & ~fb) | (fb & fc);
   endfunction

   // One beat through an otherwise idle pipeline; reports latency and result.
   task automatic send_one(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                           input logic [7:0] exp_y, input string tag);
      int lat;
      int waitc;
      @(negedge clk);
      a = ia; b = ib; c = ic; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      waitc = 0;
      while (!in_ready && waitc < 20) begin
         @(negedge clk); #1; waitc++;
      end
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk); lat++;
      end while (!out_valid && lat < 20);
      check({tag, " latency"}, 32'(lat), 32'(STAGES));
      check({tag, " y"}, 32'(y), 32'(exp_y));
   endtask

   // 16 random beats with optional consumer stall; scoreboarded in order.
   task automatic run_stream(input int stall_at, input int stall_len, input string tag,
                             output int lat, output int out_span, output int acc_span);
      logic [7:0] qa [16];
      logic [7:0] qb [16];
      logic [7:0] qc [16];
      logic [7:0] exp_q [$];
      logic [7:0] prev_y;
      logic       prev_stall;
      logic       exp_rdy;
      int sent, got, cyc, first_acc, last_acc, first_out, last_out;
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_y = '0;
      first_acc = -1; last_acc = -1; first_out = -1; last_out = -1;
      for (int i = 0; i < 16; i++) begin
         qa[i] = 8'($urandom); qb[i] = 8'($urandom); qc[i] = 8'($urandom);
      end
      while (got < 16 && cyc < 200) begin
         @(negedge clk);
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         in_valid  = (sent < 16);
         if (sent < 16) begin
            a = qa[sent]; b = qb[sent]; c = qc[sent];
         end
         #1;
         exp_rdy = (exp_q.size() < STAGES) || out_ready;
         check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
         if (out_valid && !out_ready && prev_stall) check({tag, " hold y"}, 32'(y), 32'(prev_y));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, " spurious out_valid"}, 32'(out_valid), 32'd0);
            end else begin
               check({tag, " y"}, 32'(y), 32'(exp_q.pop_front()));
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_y(a, b, c));
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      check({tag, " beats out"}, 32'(got), 32'd16);
      check({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({tag, " no extra beat"}, 32'(out_valid), 32'd0);
      end
      lat      = first_out - first_acc;
      out_span = last_out - first_out;
      acc_span = last_acc - first_acc;
   endtask

   task automatic run_bist(input logic fault, input logic [3:0] exp_err, input logic exp_pass,
                           input string tag);
      int busy_n, done_n, bad_rdy, bad_ov;
      busy_n = 0; done_n = 0; bad_rdy = 0; bad_ov = 0;
      @(negedge clk);
      fault_inject = fault; selftest_start = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         selftest_start = 1'b0;
         if (selftest_busy) begin
            busy_n++;
            if (in_ready)  bad_rdy++;
            if (out_valid) bad_ov++;
         end
         if (selftest_done) begin
            done_n++;
            check({tag, " err at done"}, 32'(err_count), 32'(exp_err));
            check({tag, " pass at done"}, 32'(selftest_pass), 32'(exp_pass));
         end
      end
      fault_inject = 1'b0;
      check({tag, " busy cycles"}, 32'(busy_n), 32'(8 + STAGES));
      check({tag, " done pulses"}, 32'(done_n), 32'd1);
      check({tag, " in_ready while busy"}, 32'(bad_rdy), 32'd0);
      check({tag, " out_valid while busy"}, 32'(bad_ov), 32'd0);
      check({tag, " err held"}, 32'(err_count), 32'(exp_err));
      check({tag, " pass held"}, 32'(selftest_pass), 32'(exp_pass));
   endtask

   initial begin
      logic [7:0] tt_exp [8];
      logic [7:0] va, vb, vc;
      int lat, out_span, acc_span, seen;
      tt_exp[0] = 8'hFF; tt_exp[1] = 8'hFF; tt_exp[2] = 8'h00; tt_exp[3] = 8'hFF;
      tt_exp[4] = 8'h00; tt_exp[5] = 8'h00; tt_exp[6] = 8'h00; tt_exp[7] = 8'hFF;

      // T1a: values held in reset, in_ready rises after release
      #2;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst y", 32'(y), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst busy", 32'(selftest_busy), 32'd0);
      check("rst done", 32'(selftest_done), 32'd0);
      check("rst pass", 32'(selftest_pass), 32'd0);
      check("rst err", 32'(err_count), 32'd0);
      #10 rst_n = 1'b1;
      #1;
      check("in_ready before first edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("in_ready after release", 32'(in_ready), 32'd1);

      // T2: truth table, all eight combinations
      for (int k = 0; k < 8; k++) begin
         va = {8{k[2]}}; vb = {8{k[1]}}; vc = {8{k[0]}};
         send_one(va, vb, vc, tt_exp[k], $sformatf("tt%0d", k));
      end

      // T3: back-to-back throughput and latency
      run_stream(1000, 0, "stream", lat, out_span, acc_span);
      check("stream latency", 32'(lat), 32'(STAGES));
      check("stream out span", 32'(out_span), 32'd15);
      check("stream accept span", 32'(acc_span), 32'd15);

      // T4: five-cycle consumer stall mid-stream
      run_stream(6, 5, "stall", lat, out_span, acc_span);
      check("stall out span", 32'(out_span), 32'd20);

      // T5: clean BIST
      run_bist(1'b0, 4'd0, 1'b1, "bist pass");

      // T6: BIST with fault injected on bit 0
      run_bist(1'b1, 4'd4, 1'b0, "bist fault");

      // T6: start ignored while a beat sits in the pipeline
      @(negedge clk);
      out_ready = 1'b0; a = 8'h0F; b = 8'h33; c = 8'h55; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      selftest_start = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         selftest_start = 1'b0;
         if (selftest_busy) seen++;
      end
      check("ignored start busy", 32'(seen), 32'd0);
      check("ignored start err kept", 32'(err_count), 32'd4);
      check("held beat valid", 32'(out_valid), 32'd1);
      check("held beat y", 32'(y), 32'(ref_y(8'h0F, 8'h33, 8'h55)));
      out_ready = 1'b1;
      @(negedge clk);
      check("held beat drained", 32'(out_valid), 32'd0);

      run_bist(1'b0, 4'd0, 1'b1, "bist rerun");

      // T1b: asynchronous reset with beats in flight
      @(negedge clk);
      out_ready = 1'b0; a = 8'hA5; b = 8'h5A; c = 8'hFF; in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst y", 32'(y), 32'd0);
      check("async rst in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flushed beats stay gone", 32'(seen), 32'd0);

      // Reset during a BIST run: no done pulse afterwards
      @(negedge clk);
      selftest_start = 1'b1;
      @(negedge clk);
      selftest_start = 1'b0;
      @(negedge clk);
      check("bist started", 32'(selftest_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst clears busy", 32'(selftest_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (selftest_done || selftest_busy) seen++;
      end
      check("aborted run silent", 32'(seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
